// File: rtl/cpu_uart_pkg.sv
// Shared types and defaults for the CPU UART blocks.
package cpu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam int DEFAULT_CLK_DIV         = 163;
    localparam int DEFAULT_SAMPLES_PER_BIT = 64;
    localparam int UART_DATA_BITS          = 8;

endpackage

// File: rtl/cpu_uart_tick_gen.sv
// Sample-tick divider: one-clk tick every CLK_DIV clks, held at phase zero while clear is high.
module cpu_uart_tick_gen
    import cpu_uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/cpu_uart_receiver.sv
// 8N1 LSB-first UART receiver for the CPU peripheral bus, oversampled off clk.
// Define CPU_UART_RX_MAJORITY_EN for a 2-of-3 vote on the start, data and stop decisions.
module cpu_uart_receiver
    import cpu_uart_pkg::*;
#(
    parameter int CLK_DIV         = DEFAULT_CLK_DIV,
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      UART_RX,
    output logic [UART_DATA_BITS-1:0] RX_DATA,
    output logic                      RX_STATUS,
    output logic                      RX_FERR,
    output logic                      RX_BUSY
);

    localparam int SCW = $clog2(SAMPLES_PER_BIT);
    localparam int BIW = $clog2(UART_DATA_BITS);
`ifdef CPU_UART_RX_MAJORITY_EN
    localparam int VOTE_DELAY = 1;
`else
    localparam int VOTE_DELAY = 0;
`endif
    // With voting every decision moves one tick later, so the third vote lands on the transition tick.
    localparam logic [SCW-1:0] START_PT = SCW'(SAMPLES_PER_BIT / 2 - 1 + VOTE_DELAY);
    localparam logic [SCW-1:0] BIT_PT   = SCW'(SAMPLES_PER_BIT - 1);

    rx_state_e                 state_q, state_d;
    logic [1:0]                sync_q, sync_d;
    logic [SCW-1:0]            sample_cnt_q, sample_cnt_d;
    logic [BIW-1:0]            bit_idx_q, bit_idx_d;
    logic [BIW:0]              bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                      rx_status_q, rx_status_d;
    logic                      rx_ferr_q, rx_ferr_d;
    logic                      rx_s, tick, sample_pt, bit_val, bits_done;

    cpu_uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign sync_d = {sync_q[0], UART_RX};
    assign rx_s   = sync_q[1];

`ifdef CPU_UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    assign hist_d  = tick ? {hist_q[0], rx_s} : hist_q;
    assign bit_val = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign bit_val = rx_s;
`endif

    assign sample_pt   = tick && (sample_cnt_q == ((state_q == START) ? START_PT : BIT_PT));
    assign bit_idx_nxt = {1'b0, bit_idx_q} + (BIW + 1)'(1);
    assign bits_done   = bit_idx_nxt[BIW];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_status_q  <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_status_q  <= rx_status_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s)                   state_d = START;
            START:     if (sample_pt)               state_d = bit_val ? IDLE : DATA;
            DATA:      if (sample_pt && bits_done)  state_d = STOP;
            STOP:      if (sample_pt)               state_d = bit_val ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s)                    state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_status_d  = 1'b0;
        rx_ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                bit_idx_d    = '0;
            end
            START, STOP: begin
                if (tick) sample_cnt_d = sample_pt ? '0 : sample_cnt_q + SCW'(1);
            end
            DATA: begin
                if (tick) sample_cnt_d = sample_pt ? '0 : sample_cnt_q + SCW'(1);
                if (sample_pt) begin
                    shift_d   = {bit_val, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_nxt[BIW-1:0];
                end
            end
            default: ;
        endcase
        if ((state_q == STOP) && sample_pt) begin
            if (bit_val) begin
                rx_data_d   = shift_q;
                rx_status_d = 1'b1;
            end else begin
                rx_ferr_d   = 1'b1;
            end
        end
    end

    assign RX_DATA   = rx_data_q;
    assign RX_STATUS = rx_status_q;
    assign RX_FERR   = rx_ferr_q;
    assign RX_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_uart_receiver.sv
// Self-checking bench for cpu_uart_receiver: directed scenarios plus random frames against a frame-level model.
module tb_cpu_uart_receiver;

    localparam int CLK_DIV = 4;
    localparam int SPB     = 16;
    localparam int BIT_CLK = CLK_DIV * SPB;
`ifdef CPU_UART_RX_MAJORITY_EN
    localparam int VOTE_TICKS = 1;
`else
    localparam int VOTE_TICKS = 0;
`endif
    // Line edge to strobe: sync + detect (3 clk) + half a start bit + 9 bit periods.
    localparam int NOM_LAT = 3 + (SPB / 2 + 9 * SPB + VOTE_TICKS) * CLK_DIV;
    localparam int LAT_TOL = 4;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS, RX_FERR, RX_BUSY;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [7:0]  model_data = 8'h00;
    int unsigned prev_pulse = 0;
    int unsigned last_pulse = 0;
    exp_t        mon_e;
    int unsigned mon_lat;

    cpu_uart_receiver #(.CLK_DIV(CLK_DIV), .SAMPLES_PER_BIT(SPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .RX_DATA   (RX_DATA),
        .RX_STATUS (RX_STATUS),
        .RX_FERR   (RX_FERR),
        .RX_BUSY   (RX_BUSY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every strobe must match the oldest outstanding frame in kind, data and timing.
    always @(negedge clk) begin
        if (reset && (RX_STATUS || RX_FERR)) begin
            check("strobe_exclusive", 32'(RX_STATUS & RX_FERR), 0);
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (exp_q.size() != 0) begin
                mon_e   = exp_q.pop_front();
                mon_lat = cyc - mon_e.t0;
                check("strobe_is_ferr", 32'(RX_FERR), 32'(mon_e.is_err));
                check("strobe_latency",
                      (mon_lat >= NOM_LAT - LAT_TOL && mon_lat <= NOM_LAT + LAT_TOL) ? NOM_LAT : mon_lat,
                      NOM_LAT);
                if (!mon_e.is_err) model_data = mon_e.data;
                check("strobe_rx_data", 32'(RX_DATA), 32'(model_data));
            end
        end
    end

    // Drive one 10-bit frame from a negedge; optional 1-clk inversion at spike_at, early exit at abort_at.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int spike_at = -1, input int abort_at = -1);
        logic [9:0] fr;
        exp_t       e;
        logic       v;
        fr       = {stop_ok, b, 1'b0};
        e.is_err = !stop_ok;
        e.data   = b;
        e.t0     = cyc;
        exp_q.push_back(e);
        for (int c = 0; c < 10 * BIT_CLK; c++) begin
            if (c == abort_at) return;
            v = fr[c / BIT_CLK];
            if (c == spike_at) v = ~v;
            UART_RX = v;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int unsigned seen;
        int          gap;
        logic [7:0]  b;
        bit          ok;

        repeat (5) @(negedge clk);
        check("rst_rx_data", 32'(RX_DATA), 0);
        check("rst_status", 32'(RX_STATUS), 0);
        check("rst_ferr", 32'(RX_FERR), 0);
        check("rst_busy", 32'(RX_BUSY), 0);
        reset = 1'b1;

        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            seen |= {29'd0, RX_BUSY, RX_STATUS, RX_FERR};
        end
        check("idle_quiet", seen, 0);
        check("idle_rx_data", 32'(RX_DATA), 0);

        send_frame(8'h55, 1'b1);
        wait_drain("drain_55", 2000);
        check("rx_data_55", 32'(RX_DATA), 32'h55);

        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_drain("drain_b2b", 2000);
        gap = int'(last_pulse - prev_pulse);
        check("b2b_gap", (gap >= 10 * BIT_CLK - 2 && gap <= 10 * BIT_CLK + 2) ? 10 * BIT_CLK : gap,
              10 * BIT_CLK);
        check("rx_data_0f", 32'(RX_DATA), 32'h0F);

        send_frame(8'h3C, 1'b0);
        repeat (300 - BIT_CLK) @(negedge clk);
        check("ferr_drained", exp_q.size(), 0);
        check("ferr_busy_low_line", 32'(RX_BUSY), 1);
        check("ferr_rx_data_kept", 32'(RX_DATA), 32'h0F);
        UART_RX = 1'b1;
        repeat (8) @(negedge clk);
        check("ferr_busy_released", 32'(RX_BUSY), 0);
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81", 2000);
        check("rx_data_81", 32'(RX_DATA), 32'h81);

        UART_RX = 1'b0;
        repeat (20) @(negedge clk);
        UART_RX = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", 32'(RX_BUSY), 0);
        check("glitch_rx_data", 32'(RX_DATA), 32'h81);

        send_frame(8'h5A, 1'b1, -1, 5 * BIT_CLK + BIT_CLK / 2);
        check("mid_busy_before_rst", 32'(RX_BUSY), 1);
        reset   = 1'b0;
        UART_RX = 1'b1;
        exp_q.delete();
        model_data = 8'h00;
        @(negedge clk);
        check("mid_rst_rx_data", 32'(RX_DATA), 0);
        check("mid_rst_status", 32'(RX_STATUS), 0);
        check("mid_rst_ferr", 32'(RX_FERR), 0);
        check("mid_rst_busy", 32'(RX_BUSY), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        send_frame(8'hC6, 1'b1);
        wait_drain("drain_after_rst", 2000);
        check("rx_data_after_rst", 32'(RX_DATA), 32'hC6);

        for (int i = 0; i < 12; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (!ok) begin
                repeat ($urandom_range(0, 200)) @(negedge clk);
                UART_RX = 1'b1;
                repeat (BIT_CLK) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 100)) @(negedge clk);
            end
        end
        wait_drain("drain_random", 2000);
        check("rx_data_random", 32'(RX_DATA), 32'(model_data));

`ifdef CPU_UART_RX_MAJORITY_EN
        // A 1-clk spike near mid bit 2 at each tick phase; at most one vote sample can see it.
        for (int off = -2; off < 2; off++) begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1, 3 * BIT_CLK + BIT_CLK / 2 + off);
            wait_drain("drain_spike", 2000);
            check("spike_rx_data", 32'(RX_DATA), 32'hFF);
        end
`endif

        repeat (BIT_CLK) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_busy", 32'(RX_BUSY), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_uart_receiver.md
Name: cpu_uart_receiver

Overview:
- UART receive path for the single-cycle CPU peripheral bus. Frame format: 8N1, LSB first.
- Oversamples the asynchronous UART_RX line using an internal tick divider off clk; no second clock.
- Delivers each received byte on RX_DATA with a one-cycle RX_STATUS strobe that the CPU peripheral register logic captures.
- Flags framing errors separately.

Parameters:
- CLK_DIV, 163: clk cycles per sample tick. 100 MHz / 163 ≈ 64 × 9600.
- SAMPLES_PER_BIT, 64: sample ticks per bit period. Must be even and ≥ 8.

Ports:
- clk  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- UART_RX  input  1  asynchronous serial line; idle high.
- RX_DATA  output  8  last correctly framed byte; held until the next good frame.
- RX_STATUS  output  1  one-clk pulse: RX_DATA updated this cycle.
- RX_FERR  output  1  one-clk pulse: stop bit sampled low; frame discarded.
- RX_BUSY  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (reset==0 at posedge clk):
  - RX_DATA=0, RX_STATUS=0, RX_FERR=0, RX_BUSY=0.
  - State=IDLE; tick counter=0; sample counter=0; bit index=0.
  - Synchronizer flops=1.
  - Reset mid-frame abandons the frame with no strobe.
- Input path: 2-flop synchronizer on UART_RX; rx_s = second flop. All decisions use rx_s.
- Tick generator: counter 0..CLK_DIV-1; tick=1 for one clk when counter==CLK_DIV-1, then wraps to 0. Cleared to 0 in IDLE so ticks align with start-edge detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 → START; sample counter=0.
  - Otherwise stay in IDLE.
- START:
  - On each tick, sample counter +1.
  - When counter reaches SAMPLES_PER_BIT/2-1 (mid start bit):
    - rx_s==0 → DATA, counter=0, bit index=0.
    - rx_s==1 → IDLE (glitch rejection; no strobe).
- DATA:
  - On each tick, counter +1.
  - At counter==SAMPLES_PER_BIT-1: shift sampled bit into shift register MSB (LSB-first line order), counter=0, bit index +1.
  - After bit index 7 is sampled → STOP.
- STOP: at counter==SAMPLES_PER_BIT-1, sample the stop bit.
  - Sample 1: RX_DATA<=shift register; RX_STATUS=1 for exactly one clk; → IDLE.
  - Sample 0: RX_FERR=1 for one clk; RX_DATA unchanged; → WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then → IDLE. Prevents a break condition from being taken as back-to-back start bits.
- Back-to-back frames: returning to IDLE at mid stop bit leaves half a bit of margin, so a start bit immediately following is detected.
- RX_STATUS and RX_FERR are never high in the same cycle. Both are registered outputs.
- Latency:
  - Start-edge timing: IDLE detects rx_s low 2–3 clk after the UART_RX falling edge.
  - Strobe timing: RX_STATUS asserts (SAMPLES_PER_BIT/2 + 9×SAMPLES_PER_BIT) × CLK_DIV clk after IDLE detects rx_s low, ±1 clk.
- Widths:
  - Tick counter: clog2(CLK_DIV) bits.
  - Sample counter: clog2(SAMPLES_PER_BIT) bits.
  - Bit index: 3 bits plus done flag. No counter may wrap unintentionally.

Optional Feature:
- Macro: CPU_UART_RX_MAJORITY_EN.
- Defined:
  - Each data and stop bit takes a 2-of-3 majority vote of rx_s at sample-counter values SAMPLES_PER_BIT-2, SAMPLES_PER_BIT-1 and the following tick (the transition tick).
  - The start-bit check uses the same vote around SAMPLES_PER_BIT/2-1.
  - Adds one tick of latency.
- Undefined: single sample at the points above; no vote registers.

Decomposition:
- Shared package cpu_uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Default CLK_DIV and SAMPLES_PER_BIT constants.
  - UART_DATA_BITS=8.
- Sub-module cpu_uart_tick_gen: parameter CLK_DIV; inputs clk, reset, clear; output tick. Reusable by the transmit side.

Test Plan (CLK_DIV=4, SAMPLES_PER_BIT=16 → bit=64 clk):
- Reset, line held high 1000 clk → RX_STATUS, RX_FERR, RX_BUSY stay 0; RX_DATA=8'h00.
- Drive frame 0x55 at 64 clk/bit → one RX_STATUS pulse ≈ 9.5 bit times after the start edge; RX_DATA=8'h55.
- Two back-to-back frames 0xA3 then 0x0F with no idle gap → two RX_STATUS pulses ~640 clk apart; RX_DATA=8'hA3 then 8'h0F.
- Frame 0x3C with stop bit driven 0, line held low 300 clk, then high:
  - one RX_FERR pulse; no RX_STATUS; RX_DATA keeps its prior value.
  - RX_BUSY stays 1 until the line returns high.
  - A following good 0x81 frame is received.
- 20-clk low glitch on idle line → no strobe; back in IDLE (RX_BUSY=0) by 40 clk after the glitch.
- Reset asserted mid-data-bit 4 of a frame → all outputs 0 next cycle. A full frame sent after reset release is received correctly.
- With CPU_UART_RX_MAJORITY_EN defined: single-clk inverted spike at mid bit 2 of 0xFF → RX_DATA=8'hFF.
